// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch predict unit:
// branch codes, 2-bit counter states and saturating helpers.
package branch_predict_unit_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  function automatic ctr_t ctr_step(ctr_t c, logic taken);
    ctr_t r;
    r = c;
    if (taken && c != ST)
      r = ctr_t'(c + 2'd1);
    else if (!taken && c != SNT)
      r = ctr_t'(c - 2'd1);
    return r;
  endfunction

  // Holds at 2^w-1 instead of wrapping; w is at most 32.
  function automatic logic [31:0] sat_inc(
    logic [31:0] v,
    int unsigned w
  );
    logic [32:0] lim;
    lim = (33'd1 << w) - 33'd1;
    return (33'(v) == lim) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_predict_unit_btb_table.sv
// Direct-mapped BTB storage: two combinational read
// ports (fetch, EX lookup) and one synchronous write port.
module btb_table
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  localparam int IDX_BITS = $clog2(ENTRIES),
  localparam int TAG_W    = XLEN - IDX_BITS - 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [XLEN-1:0]     rd_target,
  output ctr_t                rd_ctr,
  output logic                rd_jump,
  input  logic [IDX_BITS-1:0] up_idx,
  output logic                up_valid,
  output logic [TAG_W-1:0]    up_tag,
  output ctr_t                up_ctr,
  input  logic                wr_en,
  input  logic [TAG_W-1:0]    wr_tag,
  input  logic [XLEN-1:0]     wr_target,
  input  ctr_t                wr_ctr,
  input  logic                wr_jump
);

  logic             valid   [ENTRIES];
  logic [TAG_W-1:0] tags    [ENTRIES];
  logic [XLEN-1:0]  targets [ENTRIES];
  ctr_t             ctrs    [ENTRIES];
  logic             jumps   [ENTRIES];

  assign rd_valid  = valid[rd_idx];
  assign rd_tag    = tags[rd_idx];
  assign rd_target = targets[rd_idx];
  assign rd_ctr    = ctrs[rd_idx];
  assign rd_jump   = jumps[rd_idx];

  assign up_valid  = valid[up_idx];
  assign up_tag    = tags[up_idx];
  assign up_ctr    = ctrs[up_idx];

  // Reads see pre-write contents; no bypass.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        ctrs[i]  <= WNT;
      end
    end else if (wr_en) begin
      valid[up_idx]   <= 1'b1;
      tags[up_idx]    <= wr_tag;
      targets[up_idx] <= wr_target;
      ctrs[up_idx]    <= wr_ctr;
      jumps[up_idx]   <= wr_jump;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// IF-stage BTB prediction plus EX-stage branch resolution,
// mispredict redirect and saturating performance counters.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [XLEN-1:0]      FETCH_PC,
  output logic                 PREDICT_TAKEN,
  output logic [XLEN-1:0]      PREDICT_TARGET,
  input  logic                 EX_VALID,
  input  logic [XLEN-1:0]      EX_PC,
  input  logic                 BRANCH,
  input  logic                 JUMP,
  input  logic [2:0]           FUNC3,
  input  logic                 ZERO,
  input  logic                 SIGN,
  input  logic                 UNSIGNED,
  input  logic [XLEN-1:0]      BRANCH_ADDR,
  input  logic [XLEN-1:0]      JUMP_I,
  input  logic                 EX_PRED_TAKEN,
  input  logic [XLEN-1:0]      EX_PRED_TARGET,
  output logic                 REDIRECT,
  output logic [XLEN-1:0]      REDIRECT_ADDR,
  output logic [CNT_WIDTH-1:0] BRANCH_COUNT,
  output logic [CNT_WIDTH-1:0] MISPREDICT_COUNT
);

  localparam int IDX_BITS = $clog2(BTB_ENTRIES);
  localparam int TAG_W    = XLEN - IDX_BITS - 2;

  logic             f_valid, f_jump;
  logic [TAG_W-1:0] f_tag;
  logic [XLEN-1:0]  f_target;
  ctr_t             f_ctr;
  logic             f_hit;

  logic             e_valid;
  logic [TAG_W-1:0] e_tag;
  ctr_t             e_ctr;
  logic             e_hit;

  logic             cond;
  logic             actual_taken;
  logic [XLEN-1:0]  actual_target;
  logic [XLEN-1:0]  seq_pc;
  logic             update;
  logic             wr_en;
  ctr_t             wr_ctr;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^FETCH_PC[1:0];

  btb_table #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk       (CLK),
    .reset     (RESET),
    .rd_idx    (FETCH_PC[IDX_BITS+1:2]),
    .rd_valid  (f_valid),
    .rd_tag    (f_tag),
    .rd_target (f_target),
    .rd_ctr    (f_ctr),
    .rd_jump   (f_jump),
    .up_idx    (EX_PC[IDX_BITS+1:2]),
    .up_valid  (e_valid),
    .up_tag    (e_tag),
    .up_ctr    (e_ctr),
    .wr_en     (wr_en),
    .wr_tag    (EX_PC[XLEN-1:IDX_BITS+2]),
    .wr_target (actual_target),
    .wr_ctr    (wr_ctr),
    .wr_jump   (JUMP)
  );

  assign f_hit = f_valid &&
    (f_tag == FETCH_PC[XLEN-1:IDX_BITS+2]);
  assign PREDICT_TAKEN  = f_hit && (f_jump || f_ctr[1]);
  assign PREDICT_TARGET = f_hit ? f_target : '0;

  always_comb begin
    cond = 1'b0;
    case (FUNC3)
      F3_BEQ:  cond = ZERO;
      F3_BNE:  cond = ~ZERO;
      F3_BLT:  cond = SIGN;
      F3_BGE:  cond = ~SIGN;
      F3_BLTU: cond = UNSIGNED;
      F3_BGEU: cond = ~UNSIGNED;
      default: cond = 1'b0;
    endcase
  end

  assign actual_taken  = EX_VALID && (JUMP || (BRANCH && cond));
  assign actual_target = JUMP ? JUMP_I : BRANCH_ADDR;
  assign seq_pc        = EX_PC + XLEN'(4);

  assign REDIRECT = EX_VALID &&
    ((actual_taken != EX_PRED_TAKEN) ||
     (actual_taken && EX_PRED_TAKEN &&
      actual_target != EX_PRED_TARGET));
  assign REDIRECT_ADDR = actual_taken ? actual_target : seq_pc;

  // Misses only allocate when taken; hits always train.
  assign update = EX_VALID && (BRANCH || JUMP);
  assign e_hit  = e_valid &&
    (e_tag == EX_PC[XLEN-1:IDX_BITS+2]);
  assign wr_en  = update && (e_hit || actual_taken);

  always_comb begin
    wr_ctr = WT;
    if (e_hit)
      wr_ctr = ctr_step(e_ctr, actual_taken);
    else if (JUMP)
      wr_ctr = ST;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      BRANCH_COUNT     <= '0;
      MISPREDICT_COUNT <= '0;
    end else begin
      if (update)
        BRANCH_COUNT <= CNT_WIDTH'(
          sat_inc(32'(BRANCH_COUNT), CNT_WIDTH));
      if (REDIRECT)
        MISPREDICT_COUNT <= CNT_WIDTH'(
          sat_inc(32'(MISPREDICT_COUNT), CNT_WIDTH));
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Table-driven bench for branch_predict_unit; expected
// outputs are queued at drive time and checked on negedge.
module tb_branch_predict_unit;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] FETCH_PC;
  logic        PREDICT_TAKEN;
  logic [31:0] PREDICT_TARGET;
  logic        EX_VALID;
  logic [31:0] EX_PC;
  logic        BRANCH;
  logic        JUMP;
  logic [2:0]  FUNC3;
  logic        ZERO;
  logic        SIGN;
  logic        UNSIGNED;
  logic [31:0] BRANCH_ADDR;
  logic [31:0] JUMP_I;
  logic        EX_PRED_TAKEN;
  logic [31:0] EX_PRED_TARGET;
  logic        REDIRECT;
  logic [31:0] REDIRECT_ADDR;
  logic [3:0]  BRANCH_COUNT;
  logic [3:0]  MISPREDICT_COUNT;

  always #5 CLK = ~CLK;

  branch_predict_unit #(
    .XLEN        (32),
    .BTB_ENTRIES (16),
    .CNT_WIDTH   (4)
  ) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .FETCH_PC         (FETCH_PC),
    .PREDICT_TAKEN    (PREDICT_TAKEN),
    .PREDICT_TARGET   (PREDICT_TARGET),
    .EX_VALID         (EX_VALID),
    .EX_PC            (EX_PC),
    .BRANCH           (BRANCH),
    .JUMP             (JUMP),
    .FUNC3            (FUNC3),
    .ZERO             (ZERO),
    .SIGN             (SIGN),
    .UNSIGNED         (UNSIGNED),
    .BRANCH_ADDR      (BRANCH_ADDR),
    .JUMP_I           (JUMP_I),
    .EX_PRED_TAKEN    (EX_PRED_TAKEN),
    .EX_PRED_TARGET   (EX_PRED_TARGET),
    .REDIRECT         (REDIRECT),
    .REDIRECT_ADDR    (REDIRECT_ADDR),
    .BRANCH_COUNT     (BRANCH_COUNT),
    .MISPREDICT_COUNT (MISPREDICT_COUNT)
  );

  typedef struct {
    logic        rst;
    logic [31:0] fpc;
    logic        ev;
    logic [31:0] epc;
    logic        br;
    logic        jp;
    logic [2:0]  f3;
    logic        z;
    logic        s;
    logic        u;
    logic [31:0] ba;
    logic [31:0] ja;
    logic        pt;
    logic [31:0] ptg;
    logic        eptk;
    logic [31:0] eptg;
    logic        chk_red;
    logic        ered;
    logic [31:0] eraddr;
    logic [3:0]  ebc;
    logic [3:0]  emc;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  vec_t cur;
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t row(
    logic rst, logic [31:0] fpc, logic ev,
    logic [31:0] epc, logic br, logic jp,
    logic [2:0] f3, logic z, logic s, logic u,
    logic [31:0] ba, logic [31:0] ja,
    logic pt, logic [31:0] ptg,
    logic eptk, logic [31:0] eptg,
    logic ered, logic [31:0] eraddr,
    logic [3:0] ebc, logic [3:0] emc
  );
    vec_t v;
    v.rst = rst; v.fpc = fpc; v.ev = ev;
    v.epc = epc; v.br = br; v.jp = jp;
    v.f3 = f3; v.z = z; v.s = s; v.u = u;
    v.ba = ba; v.ja = ja; v.pt = pt; v.ptg = ptg;
    v.eptk = eptk; v.eptg = eptg;
    v.chk_red = 1'b1; v.ered = ered;
    v.eraddr = eraddr; v.ebc = ebc; v.emc = emc;
    return v;
  endfunction

  function automatic vec_t idle(
    logic [31:0] fpc, logic eptk,
    logic [31:0] eptg, logic [3:0] ebc,
    logic [3:0] emc
  );
    return row(F, fpc, F, 32'h0, F, F, 3'd0, F, F, F,
      32'h0, 32'h0, F, 32'h0, eptk, eptg,
      F, 32'h0, ebc, emc);
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
        name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      chk("predict_taken", 32'(PREDICT_TAKEN), 32'(cur.eptk));
      chk("predict_target", PREDICT_TARGET, cur.eptg);
      if (cur.chk_red) begin
        chk("redirect", 32'(REDIRECT), 32'(cur.ered));
        if (cur.ered)
          chk("redirect_addr", REDIRECT_ADDR, cur.eraddr);
      end
      chk("branch_count", 32'(BRANCH_COUNT), 32'(cur.ebc));
      chk("mispredict_count",
        32'(MISPREDICT_COUNT), 32'(cur.emc));
    end
  end

  task automatic apply(vec_t v);
    RESET          = v.rst;
    FETCH_PC       = v.fpc;
    EX_VALID       = v.ev;
    EX_PC          = v.epc;
    BRANCH         = v.br;
    JUMP           = v.jp;
    FUNC3          = v.f3;
    ZERO           = v.z;
    SIGN           = v.s;
    UNSIGNED       = v.u;
    BRANCH_ADDR    = v.ba;
    JUMP_I         = v.ja;
    EX_PRED_TAKEN  = v.pt;
    EX_PRED_TARGET = v.ptg;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    logic [3:0] m;

    // r0..r5: BEQ allocate, then train down to not-taken
    tbl.push_back(idle(32'h100, F, 32'h0, 4'd0, 4'd0));
    tbl.push_back(row(F, 32'h100, T, 32'h100, T, F, 3'b000,
      T, F, F, 32'h80, 32'h0, F, 32'h0,
      F, 32'h0, T, 32'h80, 4'd0, 4'd0));
    tbl.push_back(idle(32'h100, T, 32'h80, 4'd1, 4'd1));
    tbl.push_back(row(F, 32'h100, T, 32'h100, T, F, 3'b000,
      F, F, F, 32'h80, 32'h0, T, 32'h80,
      T, 32'h80, T, 32'h104, 4'd1, 4'd1));
    tbl.push_back(row(F, 32'h100, T, 32'h100, T, F, 3'b000,
      F, F, F, 32'h80, 32'h0, F, 32'h0,
      F, 32'h80, F, 32'h0, 4'd2, 4'd2));
    tbl.push_back(idle(32'h100, F, 32'h80, 4'd3, 4'd2));
    // r6..r8: BLTU taken, BGE not taken, func3 010
    tbl.push_back(row(F, 32'h144, T, 32'h144, T, F, 3'b110,
      F, F, T, 32'h40, 32'h0, F, 32'h0,
      F, 32'h0, T, 32'h40, 4'd3, 4'd2));
    tbl.push_back(row(F, 32'h144, T, 32'h148, T, F, 3'b101,
      F, T, F, 32'h60, 32'h0, F, 32'h0,
      T, 32'h40, F, 32'h0, 4'd4, 4'd3));
    tbl.push_back(row(F, 32'h148, T, 32'h14C, T, F, 3'b010,
      T, T, T, 32'h70, 32'h0, F, 32'h0,
      F, 32'h0, F, 32'h0, 4'd5, 4'd3));
    // r9..r12: JAL wrong target, then correct with BRANCH too
    tbl.push_back(row(F, 32'h14C, T, 32'h200, F, T, 3'b000,
      F, F, F, 32'h0, 32'h400, T, 32'h300,
      F, 32'h0, T, 32'h400, 4'd6, 4'd3));
    tbl.push_back(idle(32'h200, T, 32'h400, 4'd7, 4'd4));
    tbl.push_back(idle(32'h100, F, 32'h0, 4'd7, 4'd4));
    tbl.push_back(row(F, 32'h200, T, 32'h200, T, T, 3'b000,
      F, F, F, 32'h998, 32'h400, T, 32'h400,
      T, 32'h400, F, 32'h0, 4'd7, 4'd4));
    // r13..r18: non-control predicted taken, EX_VALID=0, wrap
    tbl.push_back(row(F, 32'h300, T, 32'h300, F, F, 3'b000,
      F, F, F, 32'h0, 32'h0, T, 32'h500,
      F, 32'h0, T, 32'h304, 4'd8, 4'd4));
    tbl.push_back(idle(32'h200, T, 32'h400, 4'd8, 4'd5));
    tbl.push_back(row(F, 32'h104, F, 32'h104, T, F, 3'b000,
      T, F, F, 32'h80, 32'h0, F, 32'h0,
      F, 32'h0, F, 32'h0, 4'd8, 4'd5));
    tbl.push_back(idle(32'h144, T, 32'h40, 4'd8, 4'd5));
    tbl.push_back(row(F, 32'h200, T, 32'hFFFF_FFFC, F, F,
      3'b000, F, F, F, 32'h0, 32'h0, T, 32'h10,
      T, 32'h400, T, 32'h0, 4'd8, 4'd5));
    tbl.push_back(idle(32'h0, F, 32'h0, 4'd8, 4'd6));
    // mispredict counter saturation at 15
    m = 4'd6;
    for (int i = 0; i < 20; i++) begin
      tbl.push_back(row(F, 32'h300, T, 32'h300, F, F,
        3'b000, F, F, F, 32'h0, 32'h0, T, 32'h500,
        F, 32'h0, T, 32'h304, 4'd8, m));
      m = (m == 4'd15) ? 4'd15 : m + 4'd1;
    end
    tbl.push_back(idle(32'h200, T, 32'h400, 4'd8, 4'd15));
    // reset dominates a same-cycle allocating update
    rv = row(T, 32'h200, T, 32'h180, T, F, 3'b000,
      T, F, F, 32'h90, 32'h0, F, 32'h0,
      T, 32'h400, F, 32'h0, 4'd8, 4'd15);
    rv.chk_red = 1'b0;
    tbl.push_back(rv);
    tbl.push_back(idle(32'h180, F, 32'h0, 4'd0, 4'd0));
    tbl.push_back(idle(32'h200, F, 32'h0, 4'd0, 4'd0));
    tbl.push_back(idle(32'h144, F, 32'h0, 4'd0, 4'd0));

    apply(idle(32'h0, F, 32'h0, 4'd0, 4'd0));
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    foreach (tbl[i]) begin
      @(posedge CLK);
      #1;
      apply(tbl[i]);
      exp_q.push_back(tbl[i]);
    end
    @(posedge CLK);
    #1;
    apply(idle(32'h0, F, 32'h0, 4'd0, 4'd0));
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the EX-stage branch/jump resolver.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters, queried in IF to predict taken/target.
- Resolves branches/jumps in EX, compares the outcome against the prediction carried down the pipeline, and drives redirect/flush on mispredict.
- Keeps saturating performance counters for resolved control-flow instructions and mispredicts.

Parameters:
- XLEN, 32, address/data width.
- BTB_ENTRIES, 16, number of BTB entries; must be a power of two, minimum 2.
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- CLK  input  1  clock.
- RESET  input  1  reset; synchronous, active-high.
- FETCH_PC  input  XLEN  PC being fetched in IF.
- PREDICT_TAKEN  output  1  IF prediction: redirect fetch to PREDICT_TARGET.
- PREDICT_TARGET  output  XLEN  predicted target.
- EX_VALID  input  1  EX holds a valid, non-squashed instruction.
- EX_PC  input  XLEN  PC of the EX instruction.
- BRANCH  input  1  EX instruction is a conditional branch.
- JUMP  input  1  EX instruction is JAL/JALR.
- FUNC3  input  3  branch condition code.
- ZERO  input  1  ALU result is zero (operands equal).
- SIGN  input  1  signed rs1<rs2.
- UNSIGNED  input  1  unsigned rs1<rs2.
- BRANCH_ADDR  input  XLEN  computed branch target.
- JUMP_I  input  XLEN  computed jump target.
- EX_PRED_TAKEN  input  1  prediction made for this instruction in IF.
- EX_PRED_TARGET  input  XLEN  target predicted in IF.
- REDIRECT  output  1  mispredict: flush IF/ID and load REDIRECT_ADDR.
- REDIRECT_ADDR  output  XLEN  corrected PC.
- BRANCH_COUNT  output  CNT_WIDTH  resolved branch+jump count.
- MISPREDICT_COUNT  output  CNT_WIDTH  REDIRECT-cycle count.

Behaviour:
- IDX = PC[IDX_BITS+1:2], where IDX_BITS = log2(BTB_ENTRIES).
- TAG = PC[XLEN-1:IDX_BITS+2].
- Each entry holds: valid, tag, target (XLEN), ctr (2 bits), is_jump.
- Prediction, combinational:
  - hit = valid & tag match at IDX(FETCH_PC).
  - PREDICT_TAKEN = hit & (is_jump | ctr[1]).
  - PREDICT_TARGET = entry target when hit, else 0.
- Condition, by FUNC3:
  - 000 BEQ = ZERO.
  - 001 BNE = ~ZERO.
  - 100 BLT = SIGN.
  - 101 BGE = ~SIGN.
  - 110 BLTU = UNSIGNED.
  - 111 BGEU = ~UNSIGNED.
  - 010/011 = not taken.
- actual_taken = EX_VALID & (JUMP | (BRANCH & cond)).
- actual_target = JUMP ? JUMP_I : BRANCH_ADDR. JUMP has priority if BRANCH and JUMP are both high.
- Redirect, combinational, same cycle as EX:
  - REDIRECT = EX_VALID & ((actual_taken != EX_PRED_TAKEN) | (actual_taken & EX_PRED_TAKEN & actual_target != EX_PRED_TARGET)).
  - A non-control instruction with EX_PRED_TAKEN=1 also redirects, to EX_PC+4.
  - REDIRECT_ADDR = actual_taken ? actual_target : EX_PC+4, modulo 2^XLEN. Driven every cycle, meaningful only when REDIRECT=1.
- BTB update, at the rising CLK edge when EX_VALID & (BRANCH|JUMP):
  - On tag hit: ctr moves toward the outcome, saturating at 00 and 11. Target and is_jump are rewritten.
  - On miss, taken: allocate entry (valid=1, tag, target, is_jump=JUMP). ctr=10 for a branch, 11 for a jump.
  - On miss, not taken: no allocation.
- Same-cycle read/write of one index: the fetch read returns the pre-update contents. A write is never bypassed.
- Performance counters:
  - BRANCH_COUNT increments per update cycle.
  - MISPREDICT_COUNT increments per REDIRECT cycle.
  - Both saturate at all-ones; they do not wrap.
- Reset:
  - On any CLK edge with RESET=1, all valid bits are cleared, all ctr set to 01, both counters set to 0.
  - RESET dominates a same-cycle update.
  - PREDICT_TAKEN=0 from the first cycle after reset.
  - REDIRECT stays combinational and is not gated by RESET. The pipeline holds EX_VALID=0 during reset.

Decomposition:
- Shared package holds:
  - FUNC3 branch codes (BEQ…BGEU).
  - Counter encodings: SNT=00, WNT=01, WT=10, ST=11.
  - The saturating-increment function.
- One sub-module, btb_table:
  - Storage array, combinational read port, one synchronous write port.
  - Synchronous reset clear.
- The top level holds condition evaluation, mispredict compare and counters.

Test Plan:
- Reset, then FETCH_PC=0x100 → PREDICT_TAKEN=0, both counters=0.
- BEQ at EX_PC=0x100, ZERO=1, EX_PRED_TAKEN=0, BRANCH_ADDR=0x80 → REDIRECT=1, REDIRECT_ADDR=0x80. Next cycle FETCH_PC=0x100 → PREDICT_TAKEN=1, PREDICT_TARGET=0x80, MISPREDICT_COUNT=1.
- Same branch resolved not-taken twice, each with EX_PRED_TAKEN matching the current prediction:
  - First resolve: ctr 10→01, REDIRECT=1 with REDIRECT_ADDR=0x104.
  - Second resolve: ctr 01→00, no redirect.
  - Then fetch 0x100 → PREDICT_TAKEN=0.
- BLTU with UNSIGNED=1 and BGE with SIGN=1 → taken and not-taken respectively; FUNC3=010 → never taken.
- JAL at 0x200, JUMP_I=0x400, predicted taken with EX_PRED_TARGET=0x300 → REDIRECT=1, REDIRECT_ADDR=0x400. BTB target becomes 0x400.
- CNT_WIDTH=4, 20 mispredicts → MISPREDICT_COUNT holds at 15. Assert RESET on the same cycle as an update → entry stays invalid, counters=0.
